// File: rtl/if_id_stage.sv
// Fetch-to-decode register: assembles 1/2-byte instructions into a decode packet, 1-cycle latency after last byte.
// stall freezes every register (fetch ignored); flush squashes pending/presented packet and wins over stall.
module if_id_stage #(
  parameter int          WIDTH        = 8,
  parameter logic [3:0]  TWO_BYTE_OPC = 4'd12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [WIDTH-1:0] instr_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_out,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] imm_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             two_byte_out,
  output logic [3:0]       opcode_fb,
  output logic [1:0]       brx_fb
);

  typedef enum logic [0:0] {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic             two_byte;
  } pkt_t;

  state_t           state, state_nxt;
  pkt_t             pkt, pkt_nxt;
  logic [WIDTH-1:0] first_byte, first_byte_nxt;
  logic [WIDTH-1:0] first_pc, first_pc_nxt;
  logic [3:0]       in_opc;

  assign in_opc = instr_in[WIDTH-1 -: 4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FIRST;
      pkt        <= '0;
      first_byte <= '0;
      first_pc   <= '0;
    end else begin
      state      <= state_nxt;
      pkt        <= pkt_nxt;
      first_byte <= first_byte_nxt;
      first_pc   <= first_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pkt_nxt        = pkt;
    first_byte_nxt = first_byte;
    first_pc_nxt   = first_pc;
    if (flush) begin
      // Stale data fields are harmless once valid and two_byte are cleared.
      state_nxt        = S_FIRST;
      pkt_nxt.vld      = 1'b0;
      pkt_nxt.two_byte = 1'b0;
    end else if (!stall) begin
      unique case (state)
        S_FIRST: begin
          pkt_nxt.vld = 1'b0;
          if (fetch_valid) begin
            if (in_opc == TWO_BYTE_OPC) begin
              first_byte_nxt = instr_in;
              first_pc_nxt   = pc_in;
              state_nxt      = S_SECOND;
            end else begin
              pkt_nxt.vld      = 1'b1;
              pkt_nxt.instr    = instr_in;
              pkt_nxt.imm      = '0;
              pkt_nxt.pc       = pc_in;
              pkt_nxt.two_byte = 1'b0;
            end
          end
        end
        S_SECOND: begin
          pkt_nxt.vld = 1'b0;
          if (fetch_valid) begin
            pkt_nxt.vld      = 1'b1;
            pkt_nxt.instr    = first_byte;
            pkt_nxt.imm      = instr_in;
            pkt_nxt.pc       = first_pc;
            pkt_nxt.two_byte = 1'b1;
            state_nxt        = S_FIRST;
          end
        end
        default: state_nxt = S_FIRST;
      endcase
    end
  end

  // PC control needs the opcode of the byte being fetched now, not the one presented.
  always_comb begin
    opcode_fb = pkt.instr[WIDTH-1 -: 4];
    brx_fb    = pkt.instr[3:2];
    if (state == S_SECOND) begin
      opcode_fb = first_byte[WIDTH-1 -: 4];
      brx_fb    = first_byte[3:2];
    end else if (fetch_valid) begin
      opcode_fb = in_opc;
      brx_fb    = instr_in[3:2];
    end
  end

  assign valid_out    = pkt.vld;
  assign instr_out    = pkt.instr;
  assign imm_out      = pkt.imm;
  assign pc_out       = pkt.pc;
  assign two_byte_out = pkt.two_byte;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: expected packets are queued at issue and popped by a monitor.
module tb_if_id_stage;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       two;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_valid;
  logic [7:0] instr_in;
  logic [7:0] pc_in;
  logic       stall;
  logic       flush;
  logic       valid_out;
  logic [7:0] instr_out;
  logic [7:0] imm_out;
  logic [7:0] pc_out;
  logic       two_byte_out;
  logic [3:0] opcode_fb;
  logic [1:0] brx_fb;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic held = 1'b0;

  if_id_stage #(.WIDTH(8), .TWO_BYTE_OPC(4'd12)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .instr_in    (instr_in),
    .pc_in       (pc_in),
    .stall       (stall),
    .flush       (flush),
    .valid_out   (valid_out),
    .instr_out   (instr_out),
    .imm_out     (imm_out),
    .pc_out      (pc_out),
    .two_byte_out(two_byte_out),
    .opcode_fb   (opcode_fb),
    .brx_fb      (brx_fb)
  );

  always #5 clk = ~clk;

  // A packet held by stall is the same packet, not a new one.
  always @(posedge clk) held <= stall && !flush && reset;

  always @(negedge clk) begin
    if (valid_out && !held) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_packet: got instr=%h imm=%h pc=%h two=%b, required no packet",
                 instr_out, imm_out, pc_out, two_byte_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({instr_out, imm_out, pc_out, two_byte_out} !== e) begin
          errors++;
          $display("FAIL packet: got instr=%h imm=%h pc=%h two=%b, required instr=%h imm=%h pc=%h two=%b",
                   instr_out, imm_out, pc_out, two_byte_out, e.instr, e.imm, e.pc, e.two);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step(input logic fv, input logic [7:0] ins, input logic [7:0] pc,
                      input logic st = 1'b0, input logic fl = 1'b0);
    fetch_valid = fv;
    instr_in    = ins;
    pc_in       = pc;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_pkt(input logic [7:0] ins, input logic [7:0] imm,
                            input logic [7:0] pc, input logic two);
    exp_t e;
    e = '{instr: ins, imm: imm, pc: pc, two: two};
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; fetch_valid = 1'b0; instr_in = '0; pc_in = '0; stall = 1'b0; flush = 1'b0;
    #1;
    chk("rst_valid", 16'(valid_out), 16'h0);
    chk("rst_instr", 16'(instr_out), 16'h0);
    chk("rst_imm",   16'(imm_out),   16'h0);
    chk("rst_pc",    16'(pc_out),    16'h0);
    chk("rst_two",   16'(two_byte_out), 16'h0);
    chk("rst_opc_fb", 16'(opcode_fb), 16'h0);
    @(posedge clk); #2;
    reset = 1'b1;

    // back-to-back one-byte instructions
    expect_pkt(8'h21, 8'h00, 8'h10, 1'b0); step(1'b1, 8'h21, 8'h10);
    expect_pkt(8'h4A, 8'h00, 8'h11, 1'b0); step(1'b1, 8'h4A, 8'h11);
    chk("b2b_valid", 16'(valid_out), 16'h1);

    // stall holds a presented packet
    step(1'b1, 8'h99, 8'h12, 1'b1);
    chk("stall_hold_valid", 16'(valid_out), 16'h1);
    chk("stall_hold_instr", 16'(instr_out), 16'h4A);
    chk("stall_hold_pc",    16'(pc_out),    16'h11);
    step(1'b0, 8'h00, 8'h00);
    chk("idle_valid", 16'(valid_out), 16'h0);

    // two-byte instruction with one bubble
    step(1'b1, 8'hC6, 8'h20);
    chk("two_bubble", 16'(valid_out), 16'h0);
    chk("fb_second_opc", 16'(opcode_fb), 16'hC);
    chk("fb_second_brx", 16'(brx_fb), 16'h1);
    expect_pkt(8'hC6, 8'h7F, 8'h20, 1'b1); step(1'b1, 8'h7F, 8'h21);

    // stall while waiting for the second byte
    step(1'b1, 8'hC6, 8'h30);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h55, 8'h31, 1'b1);
      chk("stall2_valid", 16'(valid_out), 16'h0);
      chk("stall2_instr", 16'(instr_out), 16'hC6);
      chk("stall2_imm",   16'(imm_out),   16'h7F);
      chk("stall2_fb",    16'(opcode_fb), 16'hC);
    end
    expect_pkt(8'hC6, 8'h7F, 8'h30, 1'b1); step(1'b1, 8'h7F, 8'h32);

    // flush squashes a half-assembled instruction
    step(1'b1, 8'hC6, 8'h40);
    step(1'b1, 8'h7F, 8'h41, 1'b0, 1'b1);
    chk("flush2_valid", 16'(valid_out), 16'h0);
    chk("flush2_two",   16'(two_byte_out), 16'h0);
    expect_pkt(8'h30, 8'h00, 8'h42, 1'b0); step(1'b1, 8'h30, 8'h42);

    // flush squashes a presented packet and ignores fetch
    step(1'b1, 8'h31, 8'h43, 1'b0, 1'b1);
    chk("flush1_valid", 16'(valid_out), 16'h0);

    // stall and flush together: flush wins
    step(1'b1, 8'hC6, 8'h50);
    step(1'b1, 8'h55, 8'h51, 1'b1, 1'b1);
    chk("stflush_valid", 16'(valid_out), 16'h0);
    expect_pkt(8'h12, 8'h00, 8'h52, 1'b0); step(1'b1, 8'h12, 8'h52);

    // combinational feedback from the fetched byte
    fetch_valid = 1'b1; instr_in = 8'hB8; pc_in = 8'h60; stall = 1'b0; flush = 1'b0;
    #1;
    chk("fb_first_opc", 16'(opcode_fb), 16'hB);
    chk("fb_first_brx", 16'(brx_fb), 16'h2);
    expect_pkt(8'hB8, 8'h00, 8'h60, 1'b0);
    @(posedge clk); #2;

    // asynchronous reset in the middle of a two-byte instruction
    step(1'b1, 8'hC5, 8'h70);
    fetch_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_valid", 16'(valid_out), 16'h0);
    chk("arst_instr", 16'(instr_out), 16'h0);
    chk("arst_imm",   16'(imm_out),   16'h0);
    chk("arst_pc",    16'(pc_out),    16'h0);
    chk("arst_two",   16'(two_byte_out), 16'h0);
    reset = 1'b1;
    expect_pkt(8'h13, 8'h00, 8'h71, 1'b0); step(1'b1, 8'h13, 8'h71);
    chk("arst_next_two", 16'(two_byte_out), 16'h0);
    chk("arst_next_valid", 16'(valid_out), 16'h1);

    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
